// File: rtl/alu.sv
// ---------------------------------------------------------------------------
// alu
//
// Purpose:
//   Integer ALU for the MIPS datapath. It computes one of eight operations on
//   operands A and B, selected by ALUOp. The result and the zero flag are
//   registered, so both are valid one clock after the operands are presented.
//   The zero flag feeds the branch-compare logic used by BEQ.
//
// Ports:
//   clk     in   1      rising-edge clock
//   reset   in   1      synchronous, active-high reset
//   A       in   WIDTH  operand A (rs)
//   B       in   WIDTH  operand B (rt or extended immediate)
//   ALUOp   in   3      operation select (see op_e)
//   ALUOut  out  WIDTH  registered result
//   zero    out  1      registered flag, 1 when the registered ALUOut is 0
// ---------------------------------------------------------------------------
module alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       ALUOp,
  output logic [WIDTH-1:0] ALUOut,
  output logic             zero
);

  // Operation encodings. All eight codes are used, so there is no
  // undefined select value.
  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_OR   = 3'd2,
    OP_AND  = 3'd3,
    OP_XOR  = 3'd4,
    OP_NOR  = 3'd5,
    OP_SLT  = 3'd6,
    OP_SLTU = 3'd7
  } op_e;

  logic [WIDTH-1:0] alu_out_d;
  logic [WIDTH-1:0] alu_out_q;
  logic             zero_d;
  logic             zero_q;
  logic             signed_lt;
  logic             unsigned_lt;

  // Both compares are evaluated all the time. SLT and SLTU then pick one of
  // them and zero-extend it into a full-width 0 or 1.
  always_comb begin
    signed_lt   = $signed(A) < $signed(B);
    unsigned_lt = A < B;
  end

  // Next-result selection. ADD and SUB wrap modulo 2^WIDTH. Carry, borrow
  // and overflow are dropped on purpose, because the datapath has no flags
  // other than zero.
  always_comb begin
    alu_out_d = '0;
    unique case (op_e'(ALUOp))
      OP_ADD:  alu_out_d = A + B;
      OP_SUB:  alu_out_d = A - B;
      OP_OR:   alu_out_d = A | B;
      OP_AND:  alu_out_d = A & B;
      OP_XOR:  alu_out_d = A ^ B;
      OP_NOR:  alu_out_d = ~(A | B);
      OP_SLT:  alu_out_d = {{(WIDTH-1){1'b0}}, signed_lt};
      OP_SLTU: alu_out_d = {{(WIDTH-1){1'b0}}, unsigned_lt};
    endcase
    zero_d = (alu_out_d == '0);
  end

  // The result register. zero is captured on the same edge as the result,
  // so it always describes the ALUOut value shown in the same cycle. Reset
  // wins over the operation sampled on the same edge. Reset leaves
  // ALUOut = 0, so zero is forced to 1 to stay consistent with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      alu_out_q <= '0;
      zero_q    <= 1'b1;
    end else begin
      alu_out_q <= alu_out_d;
      zero_q    <= zero_d;
    end
  end

  assign ALUOut = alu_out_q;
  assign zero   = zero_q;

endmodule

// File: tb/tb_alu.sv
// ---------------------------------------------------------------------------
// tb_alu
//
// Directed testbench for alu. Each vector is driven ahead of a rising edge.
// The outputs are sampled 1 ns after that edge and compared with expected
// values worked out by hand.
// ---------------------------------------------------------------------------
module tb_alu;

  localparam logic [2:0] ADD  = 3'd0;
  localparam logic [2:0] SUB  = 3'd1;
  localparam logic [2:0] OR_  = 3'd2;
  localparam logic [2:0] AND_ = 3'd3;
  localparam logic [2:0] XOR_ = 3'd4;
  localparam logic [2:0] NOR_ = 3'd5;
  localparam logic [2:0] SLT  = 3'd6;
  localparam logic [2:0] SLTU = 3'd7;

  logic        clk;
  logic        reset;
  logic [31:0] A;
  logic [31:0] B;
  logic [2:0]  ALUOp;
  logic [31:0] ALUOut;
  logic        zero;

  int checkCount;
  int failCount;

  alu #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .A     (A),
    .B     (B),
    .ALUOp (ALUOp),
    .ALUOut(ALUOut),
    .zero  (zero)
  );

  // Free-running clock with a 10 ns period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compares one observed value against its expected value and records
  // the outcome.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // Drives one vector, then waits for the edge that captures it. The task
  // returns 1 ns after that edge, which is a safe point to sample.
  task automatic applyStimulus(input logic rst, input logic [31:0] a,
                               input logic [31:0] b, input logic [2:0] op);
    reset = rst;
    A     = a;
    B     = b;
    ALUOp = op;
    @(posedge clk);
    #1;
  endtask

  // Drives one vector and checks the result and zero flag it produces.
  task automatic runVector(input string tag, input logic [31:0] a,
                           input logic [31:0] b, input logic [2:0] op,
                           input logic [31:0] expOut, input logic expZero);
    applyStimulus(1'b0, a, b, op);
    checkOutput({tag, ".out"}, ALUOut, expOut);
    checkOutput({tag, ".zero"}, {31'd0, zero}, {31'd0, expZero});
  endtask

  initial begin
    checkCount = 0;
    failCount  = 0;
    reset = 1'b1;
    A     = 32'd0;
    B     = 32'd0;
    ALUOp = ADD;

    // Reset with live operands present: reset must win.
    applyStimulus(1'b1, 32'd3, 32'd4, ADD);
    checkOutput("reset.out", ALUOut, 32'd0);
    checkOutput("reset.zero", {31'd0, zero}, 32'd1);

    // First edge after reset loads a normal result.
    runVector("add100_5", 32'd100, 32'd5, ADD, 32'd105, 1'b0);

    // Back-to-back sequence.
    runVector("sub100_5", 32'd100, 32'd5, SUB,  32'd95, 1'b0);
    runVector("or5_1",    32'd5,   32'd1, OR_,  32'd5,  1'b0);
    runVector("or5_5",    32'd5,   32'd5, OR_,  32'd5,  1'b0);
    runVector("sub5_5",   32'd5,   32'd5, SUB,  32'd0,  1'b1);

    // Wraparound at the word boundaries.
    runVector("addwrap", 32'hFFFFFFFF, 32'd1, ADD, 32'd0,        1'b1);
    runVector("subwrap", 32'd0,        32'd1, SUB, 32'hFFFFFFFF, 1'b0);

    // Bitwise logic operations.
    runVector("and", 32'hF0F0F0F0, 32'h0FF00FF0, AND_, 32'h00F000F0, 1'b0);
    runVector("or",  32'hF0F0F0F0, 32'h0FF00FF0, OR_,  32'hFFF0FFF0, 1'b0);
    runVector("xor", 32'hF0F0F0F0, 32'h0FF00FF0, XOR_, 32'hFF00FF00, 1'b0);
    runVector("nor", 32'hF0F0F0F0, 32'h0FF00FF0, NOR_, 32'h000F000F, 1'b0);
    runVector("norall", 32'hFFFFFFFF, 32'd0, NOR_, 32'd0, 1'b1);

    // Signed and unsigned compares.
    runVector("slt_m1_1",   32'hFFFFFFFF, 32'd1, SLT,  32'd1, 1'b0);
    runVector("sltu_m1_1",  32'hFFFFFFFF, 32'd1, SLTU, 32'd0, 1'b1);
    runVector("slt_min_0",  32'h80000000, 32'd0, SLT,  32'd1, 1'b0);
    runVector("sltu_min_0", 32'h80000000, 32'd0, SLTU, 32'd0, 1'b1);
    runVector("sltu_1_m1",  32'd1, 32'hFFFFFFFF, SLTU, 32'd1, 1'b0);
    runVector("slt_5_5",    32'd5, 32'd5,        SLT,  32'd0, 1'b1);

    // Input changes between edges must not reach the outputs.
    runVector("hold.base", 32'd20, 32'd22, ADD, 32'd42, 1'b0);
    A     = 32'd1;
    B     = 32'd1;
    ALUOp = SUB;
    #2;
    checkOutput("hold.out", ALUOut, 32'd42);
    checkOutput("hold.zero", {31'd0, zero}, 32'd0);

    // Mid-stream reset: the ADD on the reset edge is lost. The first edge
    // after reset is released produces the sum.
    applyStimulus(1'b1, 32'd7, 32'd8, ADD);
    checkOutput("midrst.out", ALUOut, 32'd0);
    checkOutput("midrst.zero", {31'd0, zero}, 32'd1);
    runVector("midrst.rel", 32'd7, 32'd8, ADD, 32'd15, 1'b0);

    $display("test done: total=%0d bad=%0d", checkCount, failCount);
    $finish;
  end

endmodule
